// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the data memory arbiter.
//   arb_state_t : ownership state of the arbiter (IDLE, OWN0, OWN1)
//   PORT_CORE   : port id of the MIPS core datapath
//   PORT_LOADER : port id of the loader/debug master
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Combinational two-way arbitration decision.
// Ports:
//   req   in  [1:0] raw requests, bit n = port n
//   last  in        port granted most recently
//   mask  in  [1:0] port n loses any tie when mask[n] is set
//   allow in  [1:0] port n may be granted at all (lock restriction)
//   gnt   out [1:0] one-hot grant, or zero
// Build option: MEM_ARB_ROUND_ROBIN_EN makes an unmasked tie go to the port
// other than last; without it port 0 always wins an unmasked tie.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    input  logic [1:0] allow,
    output logic [1:0] gnt
);

    logic [1:0] live;
    logic       tie_pick;

    assign live = req & allow;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last;
`else
    // Fixed priority: last has no say in tie breaking.
    logic unused_last;
    assign unused_last = last;
    assign tie_pick    = PORT_CORE;
`endif

    // A mask on exactly one side decides the tie outright; otherwise the
    // build-dependent tie rule applies.
    always_comb begin
        gnt = 2'b00;
        case (live)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (mask == 2'b01)
                    gnt = 2'b10;
                else if (mask == 2'b10)
                    gnt = 2'b01;
                else
                    gnt = tie_pick ? 2'b10 : 2'b01;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares the single-port synchronous data_memory between the core datapath
// (port 0) and the loader/debug master (port 1). Grants are combinational,
// read data returns one cycle after the grant to the port that issued it.
// A port may lock ownership for at most MAX_LOCK consecutive cycles.
// Ports:
//   clk, rst (async, active low)
//   req/we/addr/wdata/lock 0 and 1 : requester inputs
//   gnt0/gnt1                      : combinational grants
//   rvalid0/1, rdata0/1            : registered read return (rdata 0 when idle)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : data_memory side
// Build option: MEM_ARB_ROUND_ROBIN_EN (tie rule, see rr_arbiter_2).
module data_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int MAX_LOCK  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic                 lock0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic                 lock1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [WORD_SIZE-1:0] rdata0,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam int            CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_LOCK);

    arb_state_t    state, next_state;
    logic          last;
    logic [CW-1:0] hold_cnt, next_hold;
    logic          rd_pending;
    logic          rd_owner;
    logic [1:0]    lock_block, next_lock_block;

    logic          restrict0, restrict1, at_limit;
    logic [1:0]    lim_mask, mask, allow, arb_gnt, eff_lock;

    // The owner keeps exclusivity only while below the hold limit; at the
    // limit the cycle is arbitrated normally with the owner losing ties and
    // its lock ignored, which is what forces the state back to IDLE.
    assign restrict0 = (state == OWN0) && lock0 && (hold_cnt != HOLD_MAX);
    assign restrict1 = (state == OWN1) && lock1 && (hold_cnt != HOLD_MAX);
    assign at_limit  = (state != IDLE) && (hold_cnt == HOLD_MAX);
    assign lim_mask  = at_limit ? ((state == OWN0) ? 2'b01 : 2'b10) : 2'b00;
    assign mask      = lock_block | lim_mask;
    assign allow     = {~restrict0, ~restrict1};
    assign eff_lock  = {lock1, lock0} & ~mask;

    rr_arbiter_2 u_arb (
        .req   ({req1, req0}),
        .last  (last),
        .mask  (mask),
        .allow (allow),
        .gnt   (arb_gnt)
    );

    // Grants are forced low while reset is held so nothing reaches memory.
    assign gnt0 = rst & arb_gnt[0];
    assign gnt1 = rst & arb_gnt[1];

    // Next ownership state, hold counter and re-lock blocking. hold_cnt only
    // increments while restricted, which implies it is below HOLD_MAX, so it
    // saturates without an explicit compare.
    always_comb begin
        next_state = IDLE;
        next_hold  = '0;
        if (restrict0) begin
            next_state = OWN0;
            next_hold  = hold_cnt + CW'(1);
        end else if (restrict1) begin
            next_state = OWN1;
            next_hold  = hold_cnt + CW'(1);
        end else if (arb_gnt[0] && eff_lock[0]) begin
            next_state = OWN0;
            next_hold  = CW'(1);
        end else if (arb_gnt[1] && eff_lock[1]) begin
            next_state = OWN1;
            next_hold  = CW'(1);
        end
        for (int i = 0; i < 2; i++) begin
            if (lim_mask[i])
                next_lock_block[i] = 1'b1;
            else if (arb_gnt[i])
                next_lock_block[i] = lock_block[i];
            else
                next_lock_block[i] = 1'b0;
        end
    end

    // Memory-side mux; everything is zero when nobody is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // State registers; reset drops any pending read and releases locks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last       <= PORT_LOADER;
            hold_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= PORT_CORE;
            lock_block <= 2'b00;
        end else begin
            state      <= next_state;
            hold_cnt   <= next_hold;
            lock_block <= next_lock_block;
            rd_pending <= (arb_gnt[0] && !we0) || (arb_gnt[1] && !we1);
            if (arb_gnt != 2'b00) begin
                last     <= arb_gnt[1] ? PORT_LOADER : PORT_CORE;
                rd_owner <= arb_gnt[1] ? PORT_LOADER : PORT_CORE;
            end
        end
    end

    assign rvalid0 = rd_pending && (rd_owner == PORT_CORE);
    assign rvalid1 = rd_pending && (rd_owner == PORT_LOADER);
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter
// Directed bench for data_memory_arbiter with a behavioural synchronous
// memory and a read-return scoreboard. Honours MEM_ARB_ROUND_ROBIN_EN for
// tie expectations.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] mem [0:255];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          tb_last  = 1;

    always #5 clk = ~clk;

    data_memory_arbiter #(.WORD_SIZE(32), .MAX_LOCK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .lock0     (lock0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] pattern(input int a);
        return (a == 16) ? 32'hDEADBEEF : (32'hA5A50000 + 32'(a));
    endfunction

    // Behavioural single-port synchronous memory, preloaded on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    function automatic int tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (tb_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic l0,
                                  input logic r1, input logic w1, input logic [31:0] a1,
                                  input logic [31:0] d1, input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = a0 ^ 32'hFFFF0000; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    // eg: expected granted port, -1 for none
    task automatic check_output(input int eg);
        logic        e_we;
        logic [31:0] e_addr, e_wd;
        sb_t         e;
        @(negedge clk);
        check("gnt0", 32'(gnt0), 32'(eg == 0));
        check("gnt1", 32'(gnt1), 32'(eg == 1));
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (eg == 0) begin e_we = we0; e_addr = addr0; e_wd = wdata0; end
        if (eg == 1) begin e_we = we1; e_addr = addr1; e_wd = wdata1; end
        check("mem_en", 32'(mem_en), 32'(eg >= 0));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid0", 32'(rvalid0), 32'(e.port == 1'b0));
            check("rvalid1", 32'(rvalid1), 32'(e.port == 1'b1));
            check("rdata0", rdata0, (e.port == 1'b0) ? e.data : 32'h0);
            check("rdata1", rdata1, (e.port == 1'b1) ? e.data : 32'h0);
        end else begin
            check("rvalid0_idle", 32'(rvalid0), 32'h0);
            check("rvalid1_idle", 32'(rvalid1), 32'h0);
            check("rdata0_idle", rdata0, 32'h0);
            check("rdata1_idle", rdata1, 32'h0);
        end
        if (eg >= 0) begin
            tb_last = eg;
            if (e_we) ref_mem[e_addr[7:0]] = e_wd;
            else      sb.push_back('{port: 1'(eg), data: ref_mem[e_addr[7:0]], due: cyc + 1});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic l0,
                        input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic l1, input int eg);
        apply_stimulus(r0, w0, a0, l0, r1, w1, a1, d1, l1);
        check_output(eg);
    endtask

    // While reset is low everything must read zero even with requests up.
    task automatic check_reset();
        check("rst_gnt0", 32'(gnt0), 32'h0);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rvalid0", 32'(rvalid0), 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        rst = 1'b0;
        apply_stimulus(1, 0, 32'h10, 1, 1, 0, 32'h11, 32'h0, 1);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single read from port 0.
        step(1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, -1);

        // Both ports request every cycle.
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'h40 + 32'(i), 0, 1, 0, 32'h50 + 32'(i), 32'h0, 0, tie_winner());

        // Port 1 locks; port 0 waits, even while port 1 is not requesting.
        step(0, 0, 32'h0, 0, 1, 0, 32'h90, 32'h0, 1, 1);
        for (int i = 0; i < 5; i++)
            step(1, 0, 32'h91, 0, 1, 0, 32'h92 + 32'(i), 32'h0, 1, 1);
        step(1, 0, 32'h91, 0, 0, 0, 32'h0, 32'h0, 1, -1);
        step(1, 0, 32'h91, 0, 1, 0, 32'h9A, 32'h0, 0, 0);

        // Port 0 holds its lock past the limit: 16 grants, then port 1.
        step(1, 0, 32'h60, 1, 0, 0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 15; i++)
            step(1, 0, 32'h61 + 32'(i), 1, 1, 0, 32'h70, 32'h0, 0, 0);
        step(1, 0, 32'h6F, 1, 1, 0, 32'h70, 32'h0, 0, 1);
        step(1, 0, 32'h80, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Back-to-back reads 0,1,0.
        step(1, 0, 32'h20, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 1, 0, 32'h21, 32'h0, 0, 1);
        step(1, 0, 32'h22, 0, 0, 0, 32'h0, 32'h0, 0, 0);

        // Loader write, then core reads it back.
        step(0, 0, 32'h0, 0, 1, 1, 32'h30, 32'h12345678, 0, 1);
        step(1, 0, 32'h30, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, -1);

        // Reset right after a read grant drops the return.
        step(1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        sb.delete();
        tb_last = 1;
        apply_stimulus(1, 0, 32'h12, 0, 1, 0, 32'h13, 32'h0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
        step(1, 0, 32'h12, 0, 1, 0, 32'h13, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, -1);

        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port synchronous `data_memory` between two requesters: the MIPS core datapath (port 0) and a loader/debug master (port 1). It arbitrates per cycle and supports locked multi-cycle ownership with a bounded hold time. Read data returns one cycle after grant, routed to the requester that issued the read. The block sits between the core's memory signals and the `data_memory` instance.

## Interface
- `WORD_SIZE`, default 32, data and address width.
- `MAX_LOCK`, default 16, maximum consecutive cycles one requester may hold a lock (≥2).
- `clk`, in, 1, single clock, rising edge.
- `rst`, in, 1, asynchronous active-low reset.
- `req0`/`req1`, in, 1, access request; `we`/`addr`/`wdata` stay stable until granted.
- `we0`/`we1`, in, 1, 1 = write, 0 = read.
- `addr0`/`addr1`, in, WORD_SIZE, word address.
- `wdata0`/`wdata1`, in, WORD_SIZE, write data.
- `lock0`/`lock1`, in, 1, request exclusive ownership after this grant.
- `gnt0`/`gnt1`, out, 1, access accepted this cycle (combinational).
- `rvalid0`/`rvalid1`, out, 1, read data valid (registered).
- `rdata0`/`rdata1`, out, WORD_SIZE, read data; 0 when the matching `rvalid` is low.
- `mem_en`, out, 1, memory access this cycle.
- `mem_we`, out, 1, memory write enable.
- `mem_addr`, out, WORD_SIZE, memory address.
- `mem_wdata`, out, WORD_SIZE, memory write data.
- `mem_rdata`, in, WORD_SIZE, memory read data, valid one cycle after a read `mem_en`.

## Operation
- State machine `{IDLE, OWN0, OWN1}`. Registers: `last` (last granted port), `hold_cnt`, `rd_pending`, `rd_owner`.
- **IDLE:** arbitrate between the requests.
  - One request: grant it.
  - Both requests: apply the tie rule (see Configuration).
- **OWNx:**
  - While `lock_x` is high, only port x can be granted; the other port waits even if x is not requesting.
  - When `lock_x` is low, arbitration is normal in that cycle.
- **Transitions** (on the clock edge):
  - Grant to port x with `lock_x` high → OWNx, `hold_cnt` ← 1.
  - In OWNx with `lock_x` high → stay, `hold_cnt` increments.
  - In OWNx with `lock_x` low → IDLE, or OWNy if the new grant to y is locked.
  - Any other case → IDLE.
- **Hold limit:** in OWNx with `hold_cnt == MAX_LOCK`, the state is forced to IDLE regardless of `lock_x`.
  - For the next arbitration, port x loses any tie.
  - Port x cannot re-lock until it has been idle or refused for at least 1 cycle.
- **Grant side effects:** the grant drives `mem_en`=1 and muxes `we`/`addr`/`wdata` of the granted port onto the `mem_*` outputs. `last` ← granted port.
- **Reads:** a granted read sets `rd_pending`=1 and `rd_owner`=port.
  - Next cycle: `rvalid_owner`=1 and `rdata_owner`=`mem_rdata`.
  - Back-to-back reads give 1 grant/cycle and 1 rvalid/cycle.
- **Writes:** no response beyond `gnt`.
- **No request:** `mem_en`=0 and all `mem_*` outputs are 0.

## Timing
- Grant latency: 0 cycles; `gnt` is combinational from `req`, state and `last`.
- Read latency: `rvalid` 1 cycle after `gnt`.
- Throughput: 1 access per cycle.
- Reset (`rst` low, asynchronous):
  - Registers: state IDLE, `last`=1, `hold_cnt`=0, `rd_pending`=0.
  - All outputs 0 while `rst` is low, including the combinational `gnt`/`mem_*`.
- Reset mid-operation: a pending `rvalid` is dropped and any lock is released.
- First cycle after reset release: tie goes to port 0.
- `hold_cnt` saturates at `MAX_LOCK` and never wraps.
- `gnt` to a port while its previous `rvalid` is returning is legal.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: a tie in normal arbitration grants the port ≠ `last`.
- Undefined: a tie always grants port 0 (fixed priority), and `last` is unused for ties.
- Lock and hold-limit behaviour is identical in both builds.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t`
  - port id constants `PORT_CORE`=0, `PORT_LOADER`=1
- Sub-module `rr_arbiter_2`: combinational 2-way arbitration decision from `req`, `last`, `mask` and the state restriction. The macro is honoured inside it.

## Test plan
- Single read, port 0, `addr0`=0x10, memory holds 0xDEADBEEF → `gnt0` in the same cycle, `rvalid0`=1 and `rdata0`=0xDEADBEEF next cycle, `rvalid1` stays 0.
- Both request every cycle with RR enabled → grants alternate 0,1,0,1; with the macro off → port 0 granted every cycle.
- Port 1 locks for 5 cycles while port 0 requests → `gnt0`=0 for those 5 cycles; port 0 granted in the cycle `lock1` drops.
- Port 0 holds lock indefinitely with `MAX_LOCK`=16 → forced release after 16 cycles, next grant goes to port 1.
- Back-to-back reads 0,1,0 → each `rvalid` is routed to the correct port in consecutive cycles.
- `rst` asserted the cycle after a read grant → no `rvalid`, all outputs 0; after release, a tie grants port 0.
